// File: rtl/fp8_pack_stream.sv
// Multi-lane two-stage FP32 -> FP8 packer with a valid/ready stream interface.
// Per-beat rounding/overflow modes, per-lane saturation flags and a saturating event counter.
module fp8_pack_stream #(
    parameter int unsigned LANES = 4,
    parameter int unsigned E     = 4,
    parameter int unsigned M     = 3,
    parameter int unsigned BIAS  = (1 << (E - 1)) - 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [32*LANES-1:0] in_data_i,
    input  logic                rnd_mode_i,
    input  logic                ovf_mode_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [8*LANES-1:0]  out_data_o,
    output logic [LANES-1:0]    out_sat_o,
    output logic [CNT_W-1:0]    sat_cnt_o,
    input  logic                sat_clr_i
);

    localparam int unsigned REM_W   = 23 - M;
    localparam int unsigned EW      = 10;
    localparam int unsigned EXP_TOP = (1 << E) - 1;
    localparam int unsigned POP_W   = $clog2(LANES + 1);
    localparam int unsigned SUM_W   = CNT_W + POP_W;

    logic adv;
    logic s1_cap;
    logic s2_load;
    logic s1_valid_d, s1_valid_q;
    logic s2_valid_d, s2_valid_q;
    logic rnd_d, rnd_q;
    logic ovf_d, ovf_q;

    logic [LANES-1:0][7:0] conv_byte;
    logic [LANES-1:0]      conv_sat;
    logic [LANES-1:0][7:0] s2_data_d, s2_data_q;
    logic [LANES-1:0]      s2_sat_d, s2_sat_q;

    logic [POP_W-1:0] pop;
    logic [SUM_W-1:0] cnt_sum;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Both stages advance together whenever the output slot is free or being drained
    always_comb begin
        adv        = !s2_valid_q || out_ready_i;
        s1_cap     = adv && in_valid_i;
        s2_load    = adv && s1_valid_q;
        s1_valid_d = adv ? in_valid_i : s1_valid_q;
        s2_valid_d = adv ? s1_valid_q : s2_valid_q;
        rnd_d      = s1_cap ? rnd_mode_i : rnd_q;
        ovf_d      = s1_cap ? ovf_mode_i : ovf_q;
        s2_data_d  = s2_load ? conv_byte : s2_data_q;
        s2_sat_d   = s2_load ? conv_sat : s2_sat_q;
    end

    // Saturating count of flagged lanes; clear wins over a same-cycle delivery
    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + POP_W'(s2_sat_q[i]);
        end
        cnt_sum = SUM_W'(cnt_q) + SUM_W'(pop);
        cnt_d   = cnt_q;
        if (s2_valid_q && out_ready_i) begin
            cnt_d = (cnt_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : cnt_sum[CNT_W-1:0];
        end
        if (sat_clr_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            rnd_q      <= 1'b0;
            ovf_q      <= 1'b0;
            s2_data_q  <= '0;
            s2_sat_q   <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            rnd_q      <= rnd_d;
            ovf_q      <= ovf_d;
            s2_data_q  <= s2_data_d;
            s2_sat_q   <= s2_sat_d;
            cnt_q      <= cnt_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [31:0]   w;
        logic [7:0]    e32;
        logic [23:0]   sig;
        logic [31:0]   wide;
        logic [EW-1:0] e8_new;
        logic [EW-1:0] sh_full;
        logic [4:0]    sh;
        logic [M:0]    shd;
        logic          sub_new;
        logic [M:0]    kept_new;
        logic          guard_new;
        logic          sticky_new;

        logic          sign_d, sign_q;
        logic          nan_d, nan_q;
        logic          inf_d, inf_q;
        logic          sub_d, sub_q;
        logic [EW-1:0] e8_d, e8_q;
        logic [M:0]    kept_d, kept_q;
        logic          guard_d, guard_q;
        logic          sticky_d, sticky_q;

        logic          up;
        logic [M+1:0]  sum;
        logic [EW-1:0] e_rnd;
        logic [E-1:0]  exp_r;
        logic [M-1:0]  man_r;
        logic          sat_r;

        // S1: classify and split the significand into kept bits, guard and sticky
        always_comb begin
            w       = in_data_i[32*k +: 32];
            e32     = w[30:23];
            sig     = {(e32 != 8'd0), w[22:0]};
            e8_new  = EW'({2'b00, (e32 == 8'd0) ? 8'd1 : e32}) - EW'(127 - BIAS);
            sub_new = e8_new[EW-1] || (e8_new == '0);
            sh_full = EW'(23 - M) - e8_new;
            if (sh_full[EW-1]) begin
                sh = '0;
            end else if (|sh_full[EW-2:5]) begin
                sh = 5'd31;
            end else begin
                sh = sh_full[4:0];
            end
            wide = {8'd0, sig};
            shd  = (M+1)'(wide >> sh);
            if (sub_new) begin
                kept_new   = {1'b0, shd[M:1]};
                guard_new  = shd[0];
                sticky_new = |(wide & ((32'd1 << sh) - 32'd1));
            end else begin
                kept_new   = sig[23 -: (M+1)];
                guard_new  = sig[REM_W-1];
                sticky_new = |sig[REM_W-2:0];
            end

            sign_d   = sign_q;
            nan_d    = nan_q;
            inf_d    = inf_q;
            sub_d    = sub_q;
            e8_d     = e8_q;
            kept_d   = kept_q;
            guard_d  = guard_q;
            sticky_d = sticky_q;
            if (s1_cap) begin
                sign_d   = w[31];
                nan_d    = (e32 == 8'hFF) && (w[22:0] != 23'd0);
                inf_d    = (e32 == 8'hFF) && (w[22:0] == 23'd0);
                sub_d    = sub_new;
                e8_d     = e8_new;
                kept_d   = kept_new;
                guard_d  = guard_new;
                sticky_d = sticky_new;
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                sign_q   <= 1'b0;
                nan_q    <= 1'b0;
                inf_q    <= 1'b0;
                sub_q    <= 1'b0;
                e8_q     <= '0;
                kept_q   <= '0;
                guard_q  <= 1'b0;
                sticky_q <= 1'b0;
            end else begin
                sign_q   <= sign_d;
                nan_q    <= nan_d;
                inf_q    <= inf_d;
                sub_q    <= sub_d;
                e8_q     <= e8_d;
                kept_q   <= kept_d;
                guard_q  <= guard_d;
                sticky_q <= sticky_d;
            end
        end

        // Rounding; a subnormal carry into bit M lands exactly on the smallest normal
        always_comb begin
            up    = !rnd_q && guard_q && (sticky_q || kept_q[0]);
            sum   = (M+2)'(kept_q) + (M+2)'(up);
            e_rnd = e8_q + EW'(sum[M+1]);
            exp_r = '0;
            man_r = '0;
            sat_r = 1'b0;
            if (nan_q) begin
                exp_r = '1;
                man_r = M'(1);
            end else if (inf_q) begin
                exp_r = '1;
            end else if (sub_q) begin
                exp_r = E'(sum[M]);
                man_r = sum[M-1:0];
            end else if (e_rnd >= EW'(EXP_TOP)) begin
                sat_r = 1'b1;
                if (rnd_q || !ovf_q) begin
                    exp_r = E'(EXP_TOP - 1);
                    man_r = '1;
                end else begin
                    exp_r = '1;
                end
            end else begin
                exp_r = e_rnd[E-1:0];
                man_r = sum[M+1] ? '0 : sum[M-1:0];
            end
        end

        assign conv_byte[k] = {sign_q, exp_r, man_r};
        assign conv_sat[k]  = sat_r;
    end

    assign in_ready_o  = adv;
    assign out_valid_o = s2_valid_q;
    assign out_data_o  = s2_data_q;
    assign out_sat_o   = s2_sat_q;
    assign sat_cnt_o   = cnt_q;

endmodule

// File: tb/tb_fp8_pack_stream.sv
// Scoreboard bench for fp8_pack_stream: directed vectors pushed on input handshake,
// popped and compared by an independent output monitor.
module tb_fp8_pack_stream;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_data;
    logic         rnd;
    logic         ovf;
    logic         out_ready;
    logic         sat_clr;

    logic         a_in_ready, a_out_valid;
    logic [31:0]  a_out_data;
    logic [3:0]   a_out_sat;
    logic [15:0]  a_cnt;
    logic         b_in_ready, b_out_valid;
    logic [31:0]  b_out_data;
    logic [3:0]   b_out_sat;
    logic [3:0]   b_cnt;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    logic        lat_en = 1'b1;
    logic        bp_en  = 1'b0;
    int          bp_idx = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  sat;
        logic        lat;
        logic [31:0] cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct packed {
        logic [31:0] f;
        logic        r;
        logic        o;
        logic [7:0]  q;
        logic        s;
    } vec_t;

    vec_t vt [15] = '{
        '{32'h3F800000, 1'b0, 1'b0, 8'h38, 1'b0},
        '{32'hC0000000, 1'b0, 1'b0, 8'hC0, 1'b0},
        '{32'h3F880000, 1'b0, 1'b0, 8'h38, 1'b0},
        '{32'h3F980000, 1'b0, 1'b0, 8'h3A, 1'b0},
        '{32'h3F980000, 1'b1, 1'b0, 8'h39, 1'b0},
        '{32'h447A0000, 1'b0, 1'b0, 8'h77, 1'b1},
        '{32'h447A0000, 1'b0, 1'b1, 8'h78, 1'b1},
        '{32'h447A0000, 1'b1, 1'b1, 8'h77, 1'b1},
        '{32'h7FC00000, 1'b0, 1'b1, 8'h79, 1'b0},
        '{32'hFF800000, 1'b0, 1'b1, 8'hF8, 1'b0},
        '{32'h3B000000, 1'b0, 1'b0, 8'h01, 1'b0},
        '{32'h3C700000, 1'b0, 1'b0, 8'h08, 1'b0},
        '{32'h3C700000, 1'b1, 1'b0, 8'h07, 1'b0},
        '{32'h33800000, 1'b0, 1'b0, 8'h00, 1'b0},
        '{32'hC47A0000, 1'b0, 1'b1, 8'hF8, 1'b1}
    };

    logic [31:0] tv_in  [12] = '{32'h3F800000, 32'hC0000000, 32'h3F880000, 32'h3F980000,
                                 32'h3B000000, 32'h3C700000, 32'h7FC00000, 32'hFF800000,
                                 32'h00000000, 32'h40000000, 32'hBF800000, 32'h3E800000};
    logic [7:0]  tv_out [12] = '{8'h38, 8'hC0, 8'h38, 8'h3A, 8'h01, 8'h08,
                                 8'h79, 8'hF8, 8'h00, 8'h40, 8'hB8, 8'h28};
    logic        bp_pat [7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    localparam logic [127:0] HOT_IN  = {32'h3F800000, 32'h447A0000, 32'h3F800000, 32'h447A0000};
    localparam logic [31:0]  HOT_OUT = {8'h38, 8'h77, 8'h38, 8'h77};

    fp8_pack_stream u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (a_in_ready),
        .in_data_i   (in_data),
        .rnd_mode_i  (rnd),
        .ovf_mode_i  (ovf),
        .out_valid_o (a_out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (a_out_data),
        .out_sat_o   (a_out_sat),
        .sat_cnt_o   (a_cnt),
        .sat_clr_i   (sat_clr)
    );

    fp8_pack_stream #(.CNT_W(4)) u_dut_c4 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (b_in_ready),
        .in_data_i   (in_data),
        .rnd_mode_i  (rnd),
        .ovf_mode_i  (ovf),
        .out_valid_o (b_out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (b_out_data),
        .out_sat_o   (b_out_sat),
        .sat_cnt_o   (b_cnt),
        .sat_clr_i   (sat_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic send(input logic [127:0] d, input logic r, input logic o,
                        input logic [31:0] ed, input logic [3:0] es);
        logic done;
        done = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        rnd      = r;
        ovf      = o;
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clk);
            if (a_in_ready) begin
                sb.push_back('{ed, es, lat_en, 32'(cyc)});
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got=in_ready_low want=accept");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
        check("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    // Output monitor: protocol checks every cycle, scoreboard compare on each delivery
    initial begin
        logic        prev_stall;
        logic [31:0] pd;
        logic [3:0]  ps;
        exp_t        e;
        prev_stall = 1'b0;
        pd = '0;
        ps = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                check("in_ready", 64'(a_in_ready), 64'(!(a_out_valid && !out_ready)));
                if (prev_stall) begin
                    check("stall_hold", {27'd0, a_out_valid, a_out_data, a_out_sat},
                          {27'd0, 1'b1, pd, ps});
                end
                if (a_out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got=%0h want=none", a_out_data);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", 64'(a_out_data), 64'(e.data));
                        check("out_sat", 64'(a_out_sat), 64'(e.sat));
                        if (e.lat) check("latency", 64'(cyc), 64'(e.cyc + 32'd2));
                    end
                end
                prev_stall = a_out_valid && !out_ready;
                pd = a_out_data;
                ps = a_out_sat;
            end
        end
    end

    // Output backpressure pattern generator
    initial begin
        forever begin
            @(posedge clk); #1;
            if (bp_en) begin
                out_ready = bp_pat[bp_idx];
                bp_idx = (bp_idx + 1) % 7;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=time_limit want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] d;
        logic [31:0]  q;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        rnd       = 1'b0;
        ovf       = 1'b0;
        out_ready = 1'b1;
        sat_clr   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_out_data", 64'(a_out_data), 64'd0);
        check("rst_out_sat", 64'(a_out_sat), 64'd0);
        check("rst_cnt", 64'(a_cnt), 64'd0);
        check("rst_cnt_c4", 64'(b_cnt), 64'd0);
        check("rst_in_ready", 64'(a_in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed conversions on lane 0; lanes 1..3 carry fixed known values
        for (int i = 0; i < 15; i++) begin
            send({32'hC0000000, 32'h00000000, 32'h3F800000, vt[i].f}, vt[i].r, vt[i].o,
                 {8'hC0, 8'h00, 8'h38, vt[i].q}, {3'b000, vt[i].s});
        end
        idle(1);
        drain();

        // Streaming under output backpressure
        lat_en = 1'b0;
        bp_en  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) begin
                d[32*k +: 32] = tv_in[(i + k) % 12];
                q[8*k +: 8]   = tv_out[(i + k) % 12];
            end
            send(d, 1'b0, 1'b0, q, 4'b0000);
        end
        idle(1);
        drain();
        @(posedge clk); #1;
        bp_en     = 1'b0;
        out_ready = 1'b1;
        lat_en    = 1'b1;
        idle(2);

        // Counter: clear, accumulate, saturate the narrow build
        @(posedge clk); #1;
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        @(negedge clk);
        check("cnt_clear", 64'(a_cnt), 64'd0);
        check("cnt_clear_c4", 64'(b_cnt), 64'd0);
        repeat (3) send(HOT_IN, 1'b0, 1'b0, HOT_OUT, 4'b0101);
        idle(1);
        drain();
        idle(2);
        check("cnt_6", 64'(a_cnt), 64'd6);
        check("cnt_6_c4", 64'(b_cnt), 64'd6);
        repeat (5) send(HOT_IN, 1'b0, 1'b0, HOT_OUT, 4'b0101);
        idle(1);
        drain();
        idle(2);
        check("cnt_16", 64'(a_cnt), 64'd16);
        check("cnt_sat_c4", 64'(b_cnt), 64'd15);
        send(HOT_IN, 1'b0, 1'b0, HOT_OUT, 4'b0101);
        idle(1);
        @(posedge clk); #1;
        sat_clr = 1'b1;
        @(negedge clk);
        check("clr_with_handshake_valid", 64'(a_out_valid && out_ready), 64'd1);
        @(posedge clk); #1;
        sat_clr = 1'b0;
        @(negedge clk);
        check("cnt_clr_prio", 64'(a_cnt), 64'd0);
        check("cnt_clr_prio_c4", 64'(b_cnt), 64'd0);

        // Reset with two beats in flight under a stall
        send(HOT_IN, 1'b0, 1'b0, HOT_OUT, 4'b0101);
        idle(1);
        drain();
        idle(2);
        check("cnt_pre_reset", 64'(a_cnt), 64'd2);
        @(posedge clk); #1;
        out_ready = 1'b0;
        lat_en    = 1'b0;
        send(HOT_IN, 1'b0, 1'b0, HOT_OUT, 4'b0101);
        send({4{32'h3F800000}}, 1'b0, 1'b0, {4{8'h38}}, 4'b0000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        lat_en    = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 64'(a_out_valid), 64'd0);
        check("post_rst_cnt", 64'(a_cnt), 64'd0);
        check("post_rst_cnt_c4", 64'(b_cnt), 64'd0);
        check("post_rst_in_ready", 64'(a_in_ready), 64'd1);
        send({32'h3E800000, 32'hBF800000, 32'h40000000, 32'h3F980000}, 1'b0, 1'b0,
             {8'h28, 8'hB8, 8'h40, 8'h3A}, 4'b0000);
        idle(1);
        drain();
        idle(4);
        check("final_queue", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
